fifo_fnv_reader: RTL and testbench
==================================

# fifo_fnv_reader

Read-side consumer for the hasher's asynchronous byte FIFO. It pops length-prefixed messages from the FIFO read port, computes the 32-bit FNV-1a hash of each message body, and presents the result on a valid/ready output. It sits entirely in the read clock domain, between the FIFO and the result/readback logic.

## Interface
Parameters:
- DSIZE, 8, FIFO data width; only 8 is supported.
- HSIZE, 32, hash width; only 32 is supported.

Ports:
- rclk  in  1  read-domain clock; single clock for the whole block.
- rrst_n  in  1  asynchronous, active-low reset.
- rdata  in  DSIZE  FIFO read data.
- rempty  in  1  FIFO empty flag, synchronous to rclk.
- rinc  out  1  FIFO pop strobe; combinational from state and rempty.
- hash  out  HSIZE  hash accumulator and result.
- hash_valid  out  1  result available; holds until accepted.
- hash_ready  in  1  downstream accepts result when high with hash_valid.
- busy  out  1  high whenever state is not LEN.

## Operation
- Message format: byte 0 is length L (0..255), followed by L body bytes.
- FNV-1a constants: offset basis 0x811C9DC5, prime 0x01000193.
- Step: h = (h ^ {24'h0, byte}) * prime, truncated mod 2^32. Computed in a single cycle; shift-add (2^24 + 2^8 + 0x93) is permitted.
- States: LEN, HASH, DONE.
  - LEN: a pop loads remaining = rdata and h = offset. If rdata == 0, go to DONE; otherwise go to HASH.
  - HASH: a pop applies the step to the byte and decrements remaining. The pop that consumes the last byte (remaining == 1) goes to DONE.
  - DONE: hash_valid = 1 and rinc = 0. hash_valid && hash_ready returns to LEN.
- Stall: while rempty is high, rinc is 0 and state, h and remaining hold. No error is raised for a message split across a long empty period.
- rinc is never asserted while rempty is high, and never in DONE.
- Reset values: rinc 0, hash 32'h0, hash_valid 0, busy 0, state LEN, remaining 0.
- Reset mid-message: everything returns to reset values. The partial message is not resynchronised; the FIFO is reset in the same domain.

## Timing
- Fall-through mode, FIFO never empty: the length pop occurs in cycle 0 and body pops in cycles 1..L. hash_valid rises at the clock edge that ends cycle L, so it is visible from cycle L+1.
- Fall-through mode, L = 0: hash_valid is visible from cycle 1 with hash = 0x811C9DC5.
- Registered-read mode: each byte costs 2 cycles (pop cycle, then consume cycle). Latency for L bytes is 2(L+1) cycles.
- hash_valid asserted with hash_ready high: the result is accepted that cycle. The next length pop can occur in the following cycle.
- hash is stable for as long as hash_valid is high.

## Configuration
- Macro: FIFO_READER_FWFT_EN.
- Defined (FIFO built with fall-through):
  - rdata is valid whenever rempty is low.
  - The byte is consumed in the same cycle as rinc.
- Undefined (registered FIFO read):
  - A pend register is set on the pop cycle and cleared on the next cycle.
  - rdata is consumed in the cycle where pend = 1.
  - rinc is suppressed while pend = 1.
  - A pend held across reset is cleared.

## Structure
- Shared package fnv_pkg holds:
  - FNV32_OFFSET and FNV32_PRIME.
  - State encoding: LEN = 2'd0, HASH = 2'd1, DONE = 2'd2.
- Sub-module fnv1a_step: combinational, inputs h[31:0] and byte[7:0], output next h. It is reused by any later parallel hasher.
- The top level contains the FSM, the remaining counter, pend (when FWFT is off) and the accumulator register.

## Test plan
- Empty message: FIFO holds {0x00} -> hash_valid with hash = 0x811C9DC5. Exactly 1 pop.
- Single byte: FIFO holds {0x01, 0x61} -> hash = 0xE40C292C. In FWFT mode, hash_valid is visible from cycle 2.
- Six bytes, back-to-back: FIFO holds {0x06, "foobar"} followed by {0x01, 0x61} -> first result 0xBF9CF968, second result 0xE40C292C. Tie hash_ready = 1; the second length pop occurs the cycle after the first result is accepted.
- Starved FIFO: force rempty high for 5 cycles mid-"foobar" -> rinc = 0 throughout, hash is still 0xBF9CF968, and the pop count equals 7.
- Backpressure: hold hash_ready = 0 for 10 cycles in DONE -> hash_valid and hash are stable, rinc = 0, and no bytes are lost.
- Reset mid-message: assert rrst_n low after 3 body bytes -> all outputs take reset values immediately. A new {0x00} message then yields 0x811C9DC5.

Source files
------------

// File: rtl/fnv_pkg.sv
// Shared FNV-1a constants and reader state encoding.
// Imported by the step datapath and the FIFO reader.
package fnv_pkg;

    localparam logic [31:0] FNV32_OFFSET = 32'h811C9DC5;
    localparam logic [31:0] FNV32_PRIME  = 32'h01000193;

    typedef enum logic [1:0] {
        StLen  = 2'd0,
        StHash = 2'd1,
        StDone = 2'd2
    } fnv_state_e;

endpackage

// File: rtl/fifo_fnv_reader_if.sv
// Bundle between the byte FIFO read port, the FNV reader and the result consumer.
// master = reader side, slave = FIFO/consumer side.
interface fifo_fnv_reader_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned HSIZE = 32
);
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic [HSIZE-1:0] hash;
    logic             hash_valid;
    logic             hash_ready;
    logic             busy;

    modport master (
        input  rdata, rempty, hash_ready,
        output rinc, hash, hash_valid, busy
    );

    modport slave (
        output rdata, rempty, hash_ready,
        input  rinc, hash, hash_valid, busy
    );
endinterface

// File: rtl/fnv1a_step.sv
// One FNV-1a 32-bit round: h' = (h ^ byte) * prime mod 2^32, purely combinational.
module fnv1a_step
    import fnv_pkg::*;
(
    input  logic [31:0] h_i,
    input  logic [7:0]  data_i,
    output logic [31:0] h_o
);
    logic [31:0] mixed;

    assign mixed = h_i ^ {24'h0, data_i};
    assign h_o   = mixed * FNV32_PRIME;
endmodule

// File: rtl/fifo_fnv_reader.sv
// Pops length-prefixed messages from the byte FIFO and emits their FNV-1a hash.
// FIFO_READER_FWFT_EN: FIFO is fall-through; otherwise rdata lags the pop by one cycle.
module fifo_fnv_reader
    import fnv_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned HSIZE = 32
) (
    input  logic                rclk,
    input  logic                rrst_n,
    fifo_fnv_reader_if.master   bus
);
    fnv_state_e       state_q;
    logic [HSIZE-1:0] h_q;
    logic [HSIZE-1:0] h_step;
    logic [DSIZE-1:0] rem_q;
    logic             pop;
    logic             take;

    fnv1a_step u_step (
        .h_i    (h_q),
        .data_i (bus.rdata),
        .h_o    (h_step)
    );

`ifdef FIFO_READER_FWFT_EN
    assign pop  = (state_q != StDone) && !bus.rempty;
    assign take = pop;
`else
    logic pend_q;

    // Only one read in flight: the byte must land before the next pop.
    assign pop  = (state_q != StDone) && !bus.rempty && !pend_q;
    assign take = pend_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pop;
        end
    end
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= StLen;
            h_q     <= '0;
            rem_q   <= '0;
        end else if (take) begin
            case (state_q)
                StLen: begin
                    rem_q   <= bus.rdata;
                    h_q     <= FNV32_OFFSET;
                    state_q <= (bus.rdata == '0) ? StDone : StHash;
                end
                StHash: begin
                    h_q   <= h_step;
                    rem_q <= rem_q - DSIZE'(1);
                    if (rem_q == DSIZE'(1)) begin
                        state_q <= StDone;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end else if ((state_q == StDone) && bus.hash_ready) begin
            state_q <= StLen;
        end
    end

    assign bus.rinc       = pop;
    assign bus.hash       = h_q;
    assign bus.hash_valid = (state_q == StDone);
    assign bus.busy       = (state_q != StLen);
endmodule

// File: tb/tb_fifo_fnv_reader.sv
// Directed bench for fifo_fnv_reader: FIFO model, FNV-1a reference model and a
// per-cycle scoreboard on the result handshake.
module tb_fifo_fnv_reader;
`ifdef FIFO_READER_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic rclk = 1'b0;
    logic rrst_n;
    always #5 rclk = ~rclk;

    fifo_fnv_reader_if bus ();

    fifo_fnv_reader dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    logic [7:0]  fq[$];
    logic [31:0] exp_q[$];
    logic [7:0]  msg[$];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          accepts = 0;
    int          cyc = 0;
    bit          force_empty = 1'b0;
    bit          do_pop = 1'b0;
    bit          prev_acc = 1'b0;

    function automatic logic [31:0] fnv(input logic [7:0] m[$]);
        logic [31:0] h = 32'h811C9DC5;
        foreach (m[i]) h = (h ^ {24'h0, m[i]}) * 32'h01000193;
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic send(input logic [7:0] m[$]);
        fq.push_back(8'(m.size()));
        foreach (m[i]) fq.push_back(m[i]);
        exp_q.push_back(fnv(m));
    endtask

    task automatic wait_accepts(input int n, input string name);
        int lim = 0;
        while (accepts < n && lim < 2000) begin
            tick();
            lim++;
        end
        if (accepts < n) chk({name, "_timeout"}, 32'(accepts), 32'(n));
    endtask

    // Cycles from the length pop until hash_valid is first seen.
    task automatic latency(input int len, input string name);
        int c0 = -1;
        int lim = 0;
        while (c0 < 0 && lim < 50) begin
            @(negedge rclk);
            if (bus.rinc) c0 = cyc;
            lim++;
        end
        lim = 0;
        while (!bus.hash_valid && lim < 1000) begin
            @(negedge rclk);
            lim++;
        end
        chk(name, 32'(cyc - c0), FWFT ? 32'(len + 1) : 32'(2 * (len + 1)));
    endtask

    // FIFO model: pop at +1 after the edge, flags refreshed at +3 after stimulus.
    initial begin
        logic [7:0] b;
        bus.rempty = 1'b1;
        bus.rdata  = 8'h00;
        forever begin
            @(posedge rclk);
            cyc++;
            #1;
            if (do_pop && fq.size() > 0) begin
                b = fq.pop_front();
                pops++;
                if (!FWFT) bus.rdata = b;
            end
            #2;
            bus.rempty = (fq.size() == 0) || force_empty;
            if (FWFT) bus.rdata = (fq.size() != 0) ? fq[0] : 8'h00;
        end
    end

    always @(negedge rclk) begin
        if (!rrst_n) begin
            do_pop   = 1'b0;
            prev_acc = 1'b0;
        end else begin
            chk("rinc_guard", 32'(bus.rinc && (bus.rempty || bus.hash_valid)), 32'd0);
            if (prev_acc && !bus.rempty) chk("next_len_pop", 32'(bus.rinc), 32'd1);
            if (bus.hash_valid) begin
                chk("busy_in_done", 32'(bus.busy), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none", bus.hash);
                end else begin
                    chk("hash", bus.hash, exp_q[0]);
                end
            end
            prev_acc = bus.hash_valid && bus.hash_ready;
            if (prev_acc) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                accepts++;
            end
            do_pop = bus.rinc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        int          a0;
        int          lim;
        logic [31:0] h0;
        logic [7:0]  foobar[$];

        foobar = {8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72};
        rrst_n         = 1'b0;
        bus.hash_ready = 1'b0;
        #1;
        chk("rst_rinc", 32'(bus.rinc), 32'd0);
        chk("rst_hash", bus.hash, 32'h0);
        chk("rst_valid", 32'(bus.hash_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        msg = {};
        chk("model_empty", fnv(msg), 32'h811C9DC5);
        msg = {8'h61};
        chk("model_a", fnv(msg), 32'hE40C292C);
        chk("model_foobar", fnv(foobar), 32'hBF9CF968);

        tick();
        tick();
        rrst_n = 1'b1;
        tick();

        // Empty message
        bus.hash_ready = 1'b1;
        p0 = pops;
        a0 = accepts;
        msg = {};
        send(msg);
        latency(0, "lat_empty");
        chk("empty_hash", bus.hash, 32'h811C9DC5);
        wait_accepts(a0 + 1, "empty");
        chk("empty_pops", 32'(pops - p0), 32'd1);

        // Single byte
        p0 = pops;
        a0 = accepts;
        msg = {8'h61};
        send(msg);
        latency(1, "lat_single");
        chk("single_hash", bus.hash, 32'hE40C292C);
        wait_accepts(a0 + 1, "single");
        chk("single_pops", 32'(pops - p0), 32'd2);

        // Back-to-back
        p0 = pops;
        a0 = accepts;
        send(foobar);
        msg = {8'h61};
        send(msg);
        wait_accepts(a0 + 2, "b2b");
        tick();
        chk("b2b_pops", 32'(pops - p0), 32'd9);

        // Starved mid-message
        p0 = pops;
        a0 = accepts;
        exp_q.push_back(32'hBF9CF968);
        fq.push_back(8'd6);
        fq.push_back(8'h66);
        fq.push_back(8'h6f);
        fq.push_back(8'h6f);
        tick();
        tick();
        force_empty = 1'b1;
        tick();
        @(negedge rclk);
        h0 = bus.hash;
        chk("starve_rinc", 32'(bus.rinc), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge rclk);
            chk("starve_rinc", 32'(bus.rinc), 32'd0);
            chk("starve_hold", bus.hash, h0);
            chk("starve_busy", 32'(bus.busy), 32'd1);
        end
        force_empty = 1'b0;
        fq.push_back(8'h62);
        fq.push_back(8'h61);
        fq.push_back(8'h72);
        wait_accepts(a0 + 1, "starve");
        tick();
        chk("starve_pops", 32'(pops - p0), 32'd7);

        // Backpressure
        bus.hash_ready = 1'b0;
        p0 = pops;
        a0 = accepts;
        msg = {8'h61};
        send(msg);
        msg = {};
        send(msg);
        lim = 0;
        while (!bus.hash_valid && lim < 100) begin
            tick();
            lim++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            chk("bp_valid", 32'(bus.hash_valid), 32'd1);
            chk("bp_hash", bus.hash, 32'hE40C292C);
            chk("bp_rinc", 32'(bus.rinc), 32'd0);
            tick();
        end
        chk("bp_fifo_level", 32'(fq.size()), 32'd1);
        bus.hash_ready = 1'b1;
        wait_accepts(a0 + 2, "bp");
        chk("bp_pops", 32'(pops - p0), 32'd3);

        // Reset mid-message
        p0 = pops;
        send(foobar);
        lim = 0;
        while (pops - p0 < 4 && lim < 100) begin
            tick();
            lim++;
        end
        rrst_n = 1'b0;
        fq.delete();
        exp_q.delete();
        #1;
        chk("mid_rst_hash", bus.hash, 32'h0);
        chk("mid_rst_valid", 32'(bus.hash_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        #2;
        chk("mid_rst_rinc", 32'(bus.rinc), 32'd0);
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
        a0 = accepts;
        msg = {};
        send(msg);
        latency(0, "lat_after_rst");
        chk("after_rst_hash", bus.hash, 32'h811C9DC5);
        wait_accepts(a0 + 1, "after_rst");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
